// File: rtl/oscope_pkg.sv
// Shared types and defaults for the oscilloscope capture path.
// Holds the trigger FSM state encoding and buffer sizing.
package oscope_pkg;

  localparam int DEPTH_DEF        = 4096;
  localparam int AUTO_TIMEOUT_DEF = 50000;
  localparam int TO_W             = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } state_e;

endpackage

// File: rtl/trigger_capture_if.sv
// Sample stream, trigger controls and RAM write port
// shared between the sample source and trigger_capture.
interface trigger_capture_if
  import oscope_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) ();

  localparam int AW = $clog2(DEPTH);

  logic          sample_valid;
  logic [7:0]    sample;
  logic [7:0]    trig_level;
  logic          trig_slope;
  logic          auto_en;
  logic          arm;
  logic          wr_en;
  logic [AW-1:0] wr_adr;
  logic [7:0]    wr_data;
  logic          capture_done;
  logic          auto_trig;

  modport master (
    output sample_valid, sample,
    output trig_level, trig_slope,
    output auto_en, arm,
    input  wr_en, wr_adr, wr_data,
    input  capture_done, auto_trig
  );

  modport slave (
    input  sample_valid, sample,
    input  trig_level, trig_slope,
    input  auto_en, arm,
    output wr_en, wr_adr, wr_data,
    output capture_done, auto_trig
  );

endinterface

// File: rtl/trigger_capture_trig_detect.sv
// Slope/level crossing comparator between consecutive samples.
// Pure combinational; qualification by prev_ok is done by the caller.
module trig_detect (
  input  logic [7:0] prev,
  input  logic [7:0] sample,
  input  logic [7:0] level,
  input  logic       slope,
  output logic       hit
);

  logic rise;
  logic fall;

  assign rise = (prev < level) && (sample >= level);
  assign fall = (prev > level) && (sample <= level);
  assign hit  = slope ? fall : rise;

endmodule

// File: rtl/trigger_capture.sv
// Trigger FSM: arms, detects a level crossing or timeout,
// then streams DEPTH samples into the capture RAM.
module trigger_capture
  import oscope_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
  input  logic              osc_clk,
  input  logic              reset,
  trigger_capture_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(AUTO_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      prev_q, prev_d;
  logic            prev_ok_q, prev_ok_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            auto_q, auto_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_adr_q, wr_adr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            done_q, done_d;

  logic hit;
  logic hit_lvl;
  logic hit_auto;

  trig_detect u_det (
    .prev   (prev_q),
    .sample (bus.sample),
    .level  (bus.trig_level),
    .slope  (bus.trig_slope),
    .hit    (hit)
  );

  assign hit_lvl  = prev_ok_q && hit;
  assign hit_auto = bus.auto_en && (cnt_q == TO_LAST);

  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      cnt_q     <= '0;
      auto_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      cnt_q     <= cnt_d;
      auto_q    <= auto_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    cnt_d     = cnt_q;
    auto_d    = auto_q;
    wr_en_d   = 1'b0;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    // arm from any state restarts the capture; same-cycle samples are dropped
    if (bus.arm) begin
      state_d   = ARMED;
      prev_ok_d = 1'b0;
      cnt_d     = '0;
      auto_d    = 1'b0;
      wr_adr_d  = '0;
      idx_d     = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.sample_valid) begin
            prev_d    = bus.sample;
            prev_ok_d = 1'b1;
            if (bus.auto_en && cnt_q != '1)
              cnt_d = cnt_q + 1'b1;
            if (hit_lvl || hit_auto) begin
              state_d   = CAPTURE;
              auto_d    = !hit_lvl;
              wr_en_d   = 1'b1;
              wr_adr_d  = '0;
              wr_data_d = bus.sample;
              idx_d     = AW'(1);
            end
          end
        end
        CAPTURE: begin
          if (bus.sample_valid) begin
            wr_en_d   = 1'b1;
            wr_adr_d  = idx_q;
            wr_data_d = bus.sample;
            idx_d     = idx_q + 1'b1;
            if (idx_q == LAST)
              state_d = DONE;
          end
        end
        DONE:    done_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_adr       = wr_adr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.capture_done = done_q;
  assign bus.auto_trig    = auto_q;

endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter DEPTH, default 4096, number of samples per capture (power of two).
REQ-002 Parameter AUTO_TIMEOUT, default 50000, count of valid samples in ARMED before a forced trigger.
REQ-003 osc_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_valid  input  1  one-cycle strobe; sample is valid this cycle.
REQ-006 sample  input  8  unsigned ADC code, MSB-aligned.
REQ-007 trig_level  input  8  unsigned threshold; sampled on every cycle, not latched.
REQ-008 trig_slope  input  1  0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-009 auto_en  input  1  1 = enable the auto-trigger timeout.
REQ-010 arm  input  1  one-cycle request to start a new capture; pulsed by the Pi when graphing is done.
REQ-011 wr_en  output  1  one-cycle RAM write strobe.
REQ-012 wr_adr  output  log2(DEPTH)  RAM write address.
REQ-013 wr_data  output  8  RAM write data.
REQ-014 capture_done  output  1  buffer full; gates the readout stage.
REQ-015 auto_trig  output  1  the last trigger came from the timeout, not from a level crossing.

Function
REQ-016 FSM states: IDLE, ARMED, CAPTURE, DONE.
REQ-017 IDLE: wait for arm, then go to ARMED.
REQ-018 On entering ARMED: clear prev_ok, the timeout counter and auto_trig.
REQ-019 ARMED, each sample_valid: register sample as prev and set prev_ok.
REQ-020 The first valid sample after arming SHALL NOT trigger.
REQ-021 Rising trigger: prev_ok && prev < trig_level && sample >= trig_level.
REQ-022 Falling trigger: prev_ok && prev > trig_level && sample <= trig_level.
REQ-023 Auto trigger: auto_en && the timeout counter equals AUTO_TIMEOUT-1 on a valid sample that is not a level trigger; this sets auto_trig.
REQ-024 A level trigger takes priority over auto; auto_trig stays 0 when both occur.
REQ-025 Trigger behaviour: the triggering sample is written at address 0, and the FSM moves to CAPTURE.
REQ-026 CAPTURE: every sample_valid is written at the next address.
REQ-027 After DEPTH writes in total (addresses 0..DEPTH-1), go to DONE; there is no wrap and no extra write.
REQ-028 Write latency: wr_en, wr_adr and wr_data are registered and appear exactly 1 cycle after the sample_valid that produced them.
REQ-029 wr_en is high for exactly one cycle per written sample.
REQ-030 capture_done is registered and rises in the cycle after the final write strobe.
REQ-031 capture_done stays high throughout DONE.
REQ-032 DONE: no writes; go to ARMED on arm.
REQ-033 capture_done falls 1 cycle after arm.
REQ-034 arm in ARMED or CAPTURE aborts and re-enters ARMED: wr_adr goes to 0, no write in the arm cycle, and the remaining ARMED entry actions apply.
REQ-035 arm and sample_valid in the same cycle: arm wins and the sample is discarded.
REQ-036 The timeout counter saturates and never wraps; it has 16 bits.
REQ-037 While auto_en = 0 the timeout counter holds its value.
REQ-038 sample_valid outside ARMED and CAPTURE is ignored.

Reset
REQ-039 Reset enters IDLE asynchronously.
REQ-040 Reset values: wr_en = 0, wr_adr = 0, wr_data = 0, capture_done = 0, auto_trig = 0, prev_ok = 0, timeout counter = 0.
REQ-041 Reset mid-CAPTURE drops the partial buffer; no further writes until the next arm.

Structure
REQ-042 The state enum and the DEPTH and AUTO_TIMEOUT defaults SHALL live in the shared package oscope_pkg.
REQ-043 The slope/level comparator SHALL be one combinational sub-module, trig_detect (inputs prev, sample, level, slope; output hit).
REQ-044 The FSM, counters and write-port registers stay in trigger_capture.

Verification
REQ-045 Rising crossing: level = 0x80, slope = 0, samples 0x70 then 0x90 -> wr_en with wr_adr = 0, wr_data = 0x90, 1 cycle after the 0x90 strobe.
REQ-046 Falling crossing: level = 0x40, slope = 1, samples 0x50, 0x40 -> trigger on 0x40; the rising-direction sequence 0x30, 0x50 -> no trigger.
REQ-047 Full capture: DEPTH = 16, ramp after trigger -> 16 writes at addresses 0..15, capture_done rises the cycle after address 15, and a 17th sample produces no write.
REQ-048 Auto trigger: AUTO_TIMEOUT = 8, auto_en = 1, constant 0x10 -> trigger on the 8th valid sample with auto_trig = 1; with auto_en = 0 -> never triggers.
REQ-049 Abort: arm pulsed after 5 captured writes -> no write that cycle, next trigger writes at address 0, capture_done stays 0.
REQ-050 Reset asserted mid-CAPTURE (asynchronous, between clock edges) -> all outputs 0 immediately; samples ignored until arm.
